uart_receive: RTL and testbench
===============================

# uart_receive

Receive half of the FPGA↔host UART link. It is the counterpart of `uart_transmit` and samples the `uart_rxd` pin at 8N1, LSB first, at the same baud rate as the transmitter. Each completed byte goes to downstream control logic over a single-entry valid/ready holding register. The block also reports framing errors and overruns, so host-side commands can be received without corrupting the data path.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 460800: line rate. `BAUD_CYCLES = CLK_FREQ/BAUD_RATE` uses integer division (217 at defaults). `HALF_CYCLES = BAUD_CYCLES/2` (108 at defaults).
- `clk_in`, input, 1: the single system clock, `clk_100mhz` at top level.
- `rst_n_in`, input, 1: reset, asynchronous and active-low.
- `rx_wire_in`, input, 1: raw asynchronous serial line. The line idles high.
- `data_byte_out`, output, 8: received byte. Valid while `valid_out` is high.
- `valid_out`, output, 1: the holding register is full.
- `ready_in`, input, 1: consumer accepts the byte when `valid_out && ready_in` on a rising edge.
- `busy_out`, output, 1: high whenever the FSM is not in IDLE.
- `framing_error_out`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_out`, output, 1: one-cycle pulse when a completed byte is dropped.

## Operation
- Input synchronizer: 2-FF chain on `rx_wire_in`. Both flops reset to 1. All FSM decisions use the synchronized bit `rx_s`.
- FSM states are IDLE, START, DATA, STOP and WAIT_IDLE. It uses a baud counter of `$clog2(BAUD_CYCLES)` bits and a 3-bit bit index.
- IDLE:
  - If `rx_s==0`, go to START and clear the counter.
- START:
  - Count up. When the counter reaches `HALF_CYCLES-1`, sample `rx_s`.
  - If the sample is 0, go to DATA and clear the counter and bit index.
  - If the sample is 1, it was a glitch. Return to IDLE with no output.
- DATA:
  - Count 0..`BAUD_CYCLES-1`. At `BAUD_CYCLES-1`, shift `rx_s` into bit[index] of the shift register and clear the counter.
  - After index 7, go to STOP.
- STOP:
  - At `BAUD_CYCLES-1`, sample `rx_s`.
  - If the sample is 1, present the byte to the holding logic and go to IDLE.
  - If the sample is 0, pulse `framing_error_out`, discard the byte, and go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until `rx_s==1`, then go to IDLE. This stops a break condition from re-arming the receiver mid-low.
- Holding register, evaluated on the completion cycle:
  - Register empty: load the byte and set `valid_out`.
  - Register full and `ready_in` high in the same cycle: the old byte is consumed, the new byte is loaded, and `valid_out` stays high.
  - Register full and `ready_in` low: keep the old byte, drop the new one, pulse `overrun_out`.
  - Any other cycle with `valid_out && ready_in`: clear `valid_out`. `data_byte_out` holds its last value.

## Timing
- Reset values (asynchronous on `rst_n_in` low):
  - FSM = IDLE, counters = 0, shift register = 0.
  - `data_byte_out` = 0x00.
  - `valid_out`, `busy_out`, `framing_error_out`, `overrun_out` = 0.
  - Synchronizer flops = 1.
- Reset mid-frame aborts the frame; no partial byte is ever output. After release the block waits in IDLE.
- Entry into START happens 1 cycle after `rx_s` goes low, which is 3 cycles after the pin goes low.
- Sample points, counted from entry into START:
  - Start bit: `HALF_CYCLES` cycles.
  - Data bit k: `HALF_CYCLES + (k+1)*BAUD_CYCLES` cycles.
  - Stop bit: `HALF_CYCLES + 9*BAUD_CYCLES` cycles, which is 2061 at defaults.
- `valid_out` or `framing_error_out` rises on the cycle after the stop sample.
- `busy_out` is registered and follows the state with 0 latency relative to the state register.
- All outputs are registered. There are no combinational paths from `ready_in`.
- Back-to-back frames: a start edge that arrives immediately after the stop sample is detected, because IDLE is re-entered at the stop sample point.

## Structure
- Package `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - a `baud_cycles(clk, baud)` function shared with `uart_transmit`;
  - the default `BAUD_RATE` localparam, 460800.
- Sub-module `sync_2ff`: a generic reset-to-value 2-flop synchronizer. It is reused for the `btn`/`sw` inputs later.

## Test plan
- Send 0xA5 at 460800 baud, with `ready_in` held high:
  - `valid_out` pulses for 1 cycle with `data_byte_out`=0xA5.
  - The rise occurs 2064 ±1 cycles after the pin's start edge.
  - `busy_out` is high for the whole frame.
- 50-cycle low glitch on an idle line:
  - Return to IDLE at the start-sample point.
  - No `valid_out`, no `framing_error_out`.
- Frame 0x3C with the stop bit forced low, then the line held low for 1000 cycles:
  - One `framing_error_out` pulse, no `valid_out`.
  - The FSM stays in WAIT_IDLE until the line goes high.
  - The next valid frame, 0x11, is received correctly.
- `ready_in`=0, send 0x01 then 0x02:
  - `valid_out` stays high with 0x01.
  - One `overrun_out` pulse at the second completion.
  - Raising `ready_in` consumes 0x01, and `valid_out` falls.
- Back-to-back 0x00 then 0xFF with no idle gap, and `ready_in` toggled to accept on the completion cycle of the second byte:
  - Both bytes are delivered in order, with no overrun.
- Assert `rst_n_in` low during bit 4 of a frame:
  - All outputs go to reset values immediately.
  - The remainder of the frame produces no `valid_out`.
  - A subsequent 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisor helper and
// the default line rate used by both halves of the link.
package uart_pkg;

  localparam int BAUD_RATE = 460800;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Clock cycles per bit; integer division truncates toward zero.
  function automatic int baud_cycles(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value, for bringing
// asynchronous pins (serial lines, buttons, switches) into the clock domain.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments make both flops sample their inputs from
  // before the edge; blocking ones would collapse the chain into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver, LSB first, with a single-entry valid/ready holding
// register and one-cycle framing-error and overrun pulses.
module uart_receive
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = uart_pkg::BAUD_RATE
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_wire_in,
  output logic [7:0] data_byte_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       busy_out,
  output logic       framing_error_out,
  output logic       overrun_out
);

  localparam int BAUD_CYCLES = baud_cycles(CLK_FREQ, BAUD_RATE);
  localparam int HALF_CYCLES = BAUD_CYCLES / 2;
  localparam int CNT_W       = $clog2(BAUD_CYCLES);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic rx_s;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk_in),
    .rst_n(rst_n_in),
    .d    (rx_wire_in),
    .q    (rx_s)
  );

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_done;
  logic             frame_err;

  // NOTE: the shift register is reset alongside the control state so no
  // bits from an aborted frame can ever be observed after reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // NOTE: every variable gets a default before the case so each path
  // assigns all of them; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_err = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = '0;
          // Leaving at the stop sample lets an immediate next start edge in.
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next-state value so they line
  // up with the state register rather than lagging it by a cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_out          <= 1'b0;
      framing_error_out <= 1'b0;
    end else begin
      busy_out          <= (state_d != IDLE);
      framing_error_out <= frame_err;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_byte_out <= 8'h00;
      valid_out     <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      overrun_out <= 1'b0;
      if (byte_done) begin
        if (!valid_out || ready_in) begin
          data_byte_out <= shift_q;
          valid_out     <= 1'b1;
        end else begin
          overrun_out <= 1'b1;
        end
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive: directed scenarios plus random bytes,
// checked against frame-level expectations derived from the line protocol.
module tb_uart_receive;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 460800;
  localparam int B        = CLK_FREQ / BAUD;
  localparam int H        = B / 2;
  // Pin edge -> 2 sync flops -> START entry, then half a bit plus 9 bits.
  localparam int EXP_LAT  = 3 + H + 9 * B;

  logic       clk_in;
  logic       rst_n_in;
  logic       rx_wire_in;
  logic [7:0] data_byte_out;
  logic       valid_out;
  logic       ready_in;
  logic       busy_out;
  logic       framing_error_out;
  logic       overrun_out;

  uart_receive #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .rx_wire_in       (rx_wire_in),
    .data_byte_out    (data_byte_out),
    .valid_out        (valid_out),
    .ready_in         (ready_in),
    .busy_out         (busy_out),
    .framing_error_out(framing_error_out),
    .overrun_out      (overrun_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Observation only: accepted bytes and pulse counts sampled mid-cycle.
  logic [7:0] acc_q[$];
  int   n_valid_hi = 0;
  int   n_fe = 0;
  int   n_ov = 0;
  int   rise_cyc = 0;
  logic valid_prev = 1'b0;

  always @(negedge clk_in) begin
    if (valid_out && ready_in) acc_q.push_back(data_byte_out);
    if (valid_out) n_valid_hi <= n_valid_hi + 1;
    if (valid_out && !valid_prev) rise_cyc <= cyc;
    valid_prev <= valid_out;
    if (framing_error_out) n_fe <= n_fe + 1;
    if (overrun_out) n_ov <= n_ov + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int chk_idx = 0;
  int busy_gaps;
  int frame_start;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame; optionally raise ready or pulse reset at a cycle
  // offset (edges since the frame's start edge was driven).
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int rdy_at, input int rst_at);
    logic [9:0] f;
    int rel;
    f = {stop, b, 1'b0};
    frame_start = cyc;
    busy_gaps = 0;
    for (int i = 0; i < 10; i++) begin
      rx_wire_in = f[i];
      repeat (B) begin
        @(posedge clk_in);
        #1;
        rel = cyc - frame_start;
        if (rel >= 3 && rel <= EXP_LAT - 1 && !busy_out) busy_gaps++;
        if (rel == rdy_at) ready_in = 1'b1;
        if (rel == rst_at) begin
          rst_n_in = 1'b0;
          #1;
          check("rst_mid_valid", int'(valid_out), 0);
          check("rst_mid_data", int'(data_byte_out), 0);
          check("rst_mid_busy", int'(busy_out), 0);
          check("rst_mid_fe", int'(framing_error_out), 0);
          check("rst_mid_ov", int'(overrun_out), 0);
        end
        if (rel == rst_at + 10) rst_n_in = 1'b1;
      end
    end
  endtask

  task automatic check_deliveries(input string tag);
    check({tag, "_count"}, acc_q.size(), exp_q.size());
    for (int i = chk_idx; i < acc_q.size() && i < exp_q.size(); i++)
      check({tag, "_byte"}, int'(acc_q[i]), int'(exp_q[i]));
    chk_idx = exp_q.size();
  endtask

  initial begin
    int vh0, fe0, ov0, gaps, gs;
    logic [7:0] rb;

    rst_n_in   = 1'b0;
    rx_wire_in = 1'b1;
    ready_in   = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_valid", int'(valid_out), 0);
    check("reset_data", int'(data_byte_out), 0);
    check("reset_busy", int'(busy_out), 0);
    check("reset_fe", int'(framing_error_out), 0);
    check("reset_ov", int'(overrun_out), 0);
    rst_n_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;

    // 0xA5 with ready held high: latency, one-cycle valid, busy whole frame.
    ready_in = 1'b1;
    vh0 = n_valid_hi;
    send_frame(8'hA5, 1'b1, -1, -1);
    exp_q.push_back(8'hA5);
    check("a5_latency_in_window",
          int'((rise_cyc - frame_start) >= EXP_LAT - 1 &&
               (rise_cyc - frame_start) <= EXP_LAT + 1), 1);
    check("a5_valid_cycles", n_valid_hi - vh0, 1);
    check("a5_busy_gaps", busy_gaps, 0);
    check_deliveries("a5");

    // 50-cycle glitch: abandoned exactly at the start-sample point.
    vh0 = n_valid_hi;
    fe0 = n_fe;
    gs = cyc;
    rx_wire_in = 1'b0;
    for (int r = 1; r <= 300; r++) begin
      @(posedge clk_in);
      #1;
      if (cyc - gs == 50) rx_wire_in = 1'b1;
      if (cyc - gs == 3 + H - 1) check("glitch_busy_before", int'(busy_out), 1);
      if (cyc - gs == 3 + H) check("glitch_busy_after", int'(busy_out), 0);
    end
    check("glitch_no_valid", n_valid_hi - vh0, 0);
    check("glitch_no_fe", n_fe - fe0, 0);

    // 0x3C with a low stop bit, then a held break.
    vh0 = n_valid_hi;
    fe0 = n_fe;
    send_frame(8'h3C, 1'b0, -1, -1);
    gaps = 0;
    repeat (1000) begin
      @(posedge clk_in);
      #1;
      if (!busy_out) gaps++;
    end
    check("break_stays_busy", gaps, 0);
    check("break_fe_pulses", n_fe - fe0, 1);
    check("break_no_valid", n_valid_hi - vh0, 0);
    rx_wire_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    check("break_release_idle", int'(busy_out), 0);
    send_frame(8'h11, 1'b1, -1, -1);
    exp_q.push_back(8'h11);
    check_deliveries("after_break");

    // Overrun: second byte dropped while the first is held.
    ready_in = 1'b0;
    ov0 = n_ov;
    send_frame(8'h01, 1'b1, -1, -1);
    send_frame(8'h02, 1'b1, -1, -1);
    check("ovr_valid_held", int'(valid_out), 1);
    check("ovr_data_held", int'(data_byte_out), 8'h01);
    check("ovr_pulses", n_ov - ov0, 1);
    ready_in = 1'b1;
    exp_q.push_back(8'h01);
    repeat (2) @(posedge clk_in);
    #1;
    check("ovr_valid_fall", int'(valid_out), 0);
    check("ovr_data_holds", int'(data_byte_out), 8'h01);
    check_deliveries("ovr");

    // Back-to-back 0x00, 0xFF; accept exactly on the second completion.
    ready_in = 1'b0;
    ov0 = n_ov;
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, EXP_LAT - 1, -1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    check("b2b_no_overrun", n_ov - ov0, 0);
    check_deliveries("b2b");

    // Random bytes, ready high, no idle gap.
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, -1, -1);
      exp_q.push_back(rb);
    end
    check_deliveries("rand");

    // Reset during bit 4 while a byte is held; the held byte is lost.
    ready_in = 1'b0;
    send_frame(8'($urandom), 1'b1, -1, -1);
    check("pre_rst_valid", int'(valid_out), 1);
    rb = {4'hF, 4'($urandom)};
    send_frame(rb, 1'b1, -1, 5 * B + 65);
    vh0 = n_valid_hi;
    fe0 = n_fe;
    repeat (50) @(posedge clk_in);
    #1;
    check("rst_rest_no_valid", n_valid_hi - vh0, 0);
    check("rst_rest_no_fe", n_fe - fe0, 0);
    ready_in = 1'b1;
    send_frame(8'h5A, 1'b1, -1, -1);
    exp_q.push_back(8'h5A);
    repeat (5) @(posedge clk_in);
    #1;
    check_deliveries("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
